// File: rtl/counter_rev_param.sv
// counter_rev_param: parametrised reversible (up/down) counter.
//   Synchronous parallel load with clamp to MAX, count enable, programmable
//   modulus 0..MAX and three terminal-count modes: wrap, saturate and one-shot.
//   Rc is a combinational terminal count for cascading. done is a sticky
//   one-shot completion flag.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   en     count enable
//   s      direction, 1 = up, 0 = down
//   Load   synchronous parallel load (takes priority over en)
//   PData  load value, clamped to MAX
//   mode   00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   cnt    registered count
//   Rc     terminal count: en & term & ~rst
//   done   registered one-shot completion flag
module counter_rev_param #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s,
  input  logic             Load,
  input  logic [WIDTH-1:0] PData,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] cnt,
  output logic             Rc,
  output logic             done
);

  typedef enum logic {
    ARMED   = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_SHOT = 2'b10;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             term;

  // Terminal condition depends on the live direction, so a direction flip
  // at 0 or MAX moves Rc without waiting for an edge.
  assign term = s ? (cnt == MAX) : (cnt == '0);
  assign Rc   = en & term & ~rst;

  // The DONE state is the sticky flag; it comes straight off the state flop.
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      state <= ARMED;
    end else begin
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    if (Load) begin
      cnt_nxt   = (PData > MAX) ? MAX : PData;
      state_nxt = ARMED;
    end else if (state == ST_DONE) begin
      // Leaving DONE on a mode change spends that edge re-arming; counting
      // under the new mode starts on the following edge.
      if (mode != MODE_SHOT) state_nxt = ARMED;
    end else if (en) begin
      if (!term) begin
        cnt_nxt = s ? cnt + 1'b1 : cnt - 1'b1;
      end else begin
        case (mode)
          MODE_SAT:  cnt_nxt   = cnt;
          MODE_SHOT: state_nxt = ST_DONE;
          default:   cnt_nxt   = s ? '0 : MAX;
        endcase
      end
    end
  end

endmodule
